fifo_sync_param: RTL and testbench

Parametrised synchronous FIFO, the next generation of `fifo_sync`, with configurable data width, depth and almost-full/almost-empty thresholds. It adds an occupancy count, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode. It sits between a single-clock producer and consumer as a drop-in buffer. With default parameters and FWFT=0 it is port- and behaviour-compatible with `fifo_sync` on the shared ports.

---
 rtl/fifo_sync_param.sv | 110 +++++++++++
 tb/tb_fifo_sync_param.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module  : fifo_sync_param
// Purpose : Parametrised single-clock FIFO with occupancy count, sticky
//           overflow/underflow flags and optional first-word-fall-through.
// Rev     : 1.0  initial release
// ============================================================================
module fifo_sync_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic                       ren,
  input  logic                       clr_err,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_ovf_evt;
  logic w_udf_evt;

  assign w_full    = (r_count == C_DEPTH);
  assign w_empty   = (r_count == '0);
  // A write into a full FIFO is still accepted when a read frees the slot.
  assign w_wr_acc  = wen && (!w_full || ren);
  assign w_rd_acc  = ren && !w_empty;
  assign w_ovf_evt = wen && w_full && !ren;
  assign w_udf_evt = ren && w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow  <= (r_overflow  && !clr_err) || w_ovf_evt;
      r_underflow <= (r_underflow && !clr_err) || w_udf_evt;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = r_mem[r_rd_ptr];
    end else begin : g_registered
      logic [DATA_W-1:0] r_data_out;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data_out <= '0;
        end else if (w_rd_acc) begin
          r_data_out <= r_mem[r_rd_ptr];
        end
      end
      assign data_out = r_data_out;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_sync_param
// Purpose : Scoreboard bench driving a registered-read and an FWFT instance.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fifo_sync_param;

  localparam int DW = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wen = 1'b0;
  logic          ren = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] dout_r, dout_f;
  logic          full_r, empty_r, af_r, ae_r, ovf_r, udf_r;
  logic          full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [3:0]    cnt_r, cnt_f;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_udf;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren), .clr_err(clr_err), .data_in(data_in),
    .data_out(dout_r), .full(full_r), .empty(empty_r), .almost_full(af_r),
    .almost_empty(ae_r), .count(cnt_r), .overflow(ovf_r), .underflow(udf_r));

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren), .clr_err(clr_err), .data_in(data_in),
    .data_out(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(cnt_f), .overflow(ovf_f), .underflow(udf_f));

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("count", DW'(cnt_r), DW'(sz));
    chk("full", DW'(full_r), DW'(sz == DEPTH));
    chk("empty", DW'(empty_r), DW'(sz == 0));
    chk("almost_full", DW'(af_r), DW'(sz >= 6));
    chk("almost_empty", DW'(ae_r), DW'(sz <= 2));
    chk("overflow", DW'(ovf_r), DW'(m_ovf));
    chk("underflow", DW'(udf_r), DW'(m_udf));
    chk("data_out", dout_r, m_dout);
    chk("fwft_count", DW'(cnt_f), DW'(sz));
    chk("fwft_empty", DW'(empty_f), DW'(sz == 0));
    chk("fwft_flags", DW'({full_f, af_f, ae_f, ovf_f, udf_f}),
        DW'({sz == DEPTH, sz >= 6, sz <= 2, m_ovf, m_udf}));
    if (sz > 0) chk("fwft_head", dout_f, q[0]);
  endtask

  // One clock: drive inputs, advance the reference model, check after the edge.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic clr = 1'b0);
    int  sz;
    logic wacc, racc;
    wen = w; ren = r; data_in = d; clr_err = clr;
    sz   = q.size();
    wacc = w && (sz < DEPTH || r);
    racc = r && (sz > 0);
    m_ovf = (m_ovf && !clr) || (w && sz == DEPTH && !r);
    m_udf = (m_udf && !clr) || (r && sz == 0);
    if (racc) m_dout = q.pop_front();
    if (wacc) q.push_back(d);
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
    check_all();
  endtask

  // Reset asserted in the middle of a cycle; state must clear without a clock edge.
  task automatic mid_reset();
    #3;
    rst = 1'b1;
    #1;
    q.delete();
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    chk("rst_count", DW'(cnt_r), 0);
    chk("rst_empty", DW'(empty_r), 1);
    chk("rst_data_out", dout_r, 0);
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk);
    #1;
    mid_reset();

    for (int k = 1; k <= 8; k++) cycle(1'b1, 1'b0, DW'(10 * k));
    cycle(1'b1, 1'b0, 90);
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, 0);
    chk("hold_after_underflow", dout_r, 80);
    cycle(1'b0, 1'b0, 0, 1'b1);

    for (int k = 1; k <= 8; k++) cycle(1'b1, 1'b0, DW'(10 * k));
    cycle(1'b1, 1'b1, 99);
    chk("full_rw_data", dout_r, 10);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 0);
    chk("late_99", dout_r, 99);

    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, DW'(1) << i);
      cycle(1'b0, 1'b1, 0);
    end

    cycle(1'b1, 1'b1, 32'h55);
    cycle(1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 0, 1'b1);

    for (int k = 0; k < 20; k++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    cycle(1'b0, 1'b0, 0, 1'b1);

    for (int k = 1; k <= 3; k++) cycle(1'b1, 1'b0, DW'(k + 100));
    mid_reset();
    cycle(1'b1, 1'b0, 7);
    cycle(1'b0, 1'b1, 0);
    chk("post_reset_read", dout_r, 7);

    cycle(1'b1, 1'b0, 5);
    chk("fwft_no_ren", dout_f, 5);
    cycle(1'b0, 1'b1, 0);
    cycle(1'b1, 1'b0, 6);
    chk("fwft_second", dout_f, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
